// File: rtl/fib_sequencer_if.sv
// fib_sequencer_if: request/term-stream bundle between a requesting master and fib_sequencer.
interface fib_sequencer_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             abort;
  logic [WIDTH-1:0] term;
  logic [CNT_W-1:0] term_idx;
  logic             term_valid;
  logic             term_ready;
  logic             busy;
  logic             done;
  logic             ovf;
  modport master (output start, n_terms, abort, term_ready,
                  input  term, term_idx, term_valid, busy, done, ovf);
  modport slave  (input  start, n_terms, abort, term_ready,
                  output term, term_idx, term_valid, busy, done, ovf);
endinterface

// File: rtl/fib_sequencer.sv
// fib_sequencer: emits n_terms Fibonacci terms on a valid/ready stream, then pulses done.
// Define FIB_OVF_CHECK_EN to stop early with a sticky ovf when a term no longer fits in WIDTH.
module fib_sequencer #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) (
  input logic            clock,
  input logic            reset,
  fib_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a, b, nxt;
  logic [CNT_W-1:0] idx, n;
  logic             xfer, last, stop;
  assign xfer = state == EMIT && bus.term_ready;
  assign last = idx == n - CNT_W'(1);
`ifdef FIB_OVF_CHECK_EN
  logic carry, b_ovf, ovf;
  assign {carry, nxt} = {1'b0, a} + {1'b0, b};
  assign stop = b_ovf;
  assign bus.ovf = ovf;
  always_ff @(posedge clock) begin
    if (!reset) begin
      b_ovf <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      b_ovf <= 1'b0;
      ovf   <= 1'b0;
    end else if (xfer && !bus.abort && !last) begin
      b_ovf <= b_ovf | carry;
      ovf   <= ovf | b_ovf;
    end
  end
`else
  assign nxt = a + b;
  assign stop = 1'b0;
  assign bus.ovf = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      idx   <= '0;
      n     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= bus.n_terms != '0 ? EMIT : DONE;
          a     <= '0;
          b     <= WIDTH'(1);
          idx   <= '0;
          n     <= bus.n_terms;
        end
        EMIT: if (bus.abort) state <= IDLE;
          else if (xfer && (last || stop)) state <= DONE;
          else if (xfer) begin
            a   <= b;
            b   <= nxt;
            idx <= idx + CNT_W'(1);
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.term       = a;
  assign bus.term_idx   = idx;
  assign bus.term_valid = state == EMIT;
  assign bus.busy       = state != IDLE;
  assign bus.done       = state == DONE;
endmodule

// File: tb/tb_fib_sequencer.sv
// tb_fib_sequencer: directed and randomized sequences checked against an arithmetic Fibonacci model.
module tb_fib_sequencer;
  localparam int W = 6, C = 4;
  logic clock = 1'b0, reset = 1'b0;
  int tests = 0, fails = 0;
  int exp_q[$];
  bit exp_ovf;
  fib_sequencer_if #(.WIDTH(W), .CNT_W(C)) bus();
  fib_sequencer #(.WIDTH(W), .CNT_W(C)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Terms that should appear for a request of n, plus whether overflow ends it early.
  task automatic build_model(input int n);
    int f0 = 0, f1 = 1, t;
    exp_q.delete();
    exp_ovf = 0;
    for (int i = 0; i < n; i++) begin
`ifdef FIB_OVF_CHECK_EN
      if (f0 >= 2**W) begin
        exp_ovf = 1;
        break;
      end
      exp_q.push_back(f0);
`else
      exp_q.push_back(f0 % (2**W));
`endif
      t = f0 + f1;
      f0 = f1;
      f1 = t;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_term"}, bus.term, 0);
    chk({tag, "_idx"}, bus.term_idx, 0);
    chk({tag, "_valid"}, bus.term_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
  endtask

  // rmode: 0 ready held high, 1 ready pattern 1,0,0 repeating, 2 random ready
  task automatic run_seq(input int n, input int rmode);
    int got = 0, cyc = 0;
    logic r, was_stall = 1'b0;
    logic [W-1:0] held = '0;
    build_model(n);
    bus.start = 1'b1;
    bus.n_terms = C'(n);
    step();
    bus.start = 1'b0;
    while (!bus.done && cyc < 100) begin
      chk("busy", bus.busy, 1);
      chk("valid", bus.term_valid, got < exp_q.size());
      if (bus.term_valid && got < exp_q.size()) begin
        chk("term", bus.term, exp_q[got]);
        chk("idx", bus.term_idx, got);
        if (was_stall) chk("stable", bus.term, held);
      end
      r = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      bus.term_ready = r;
      was_stall = bus.term_valid && !r;
      held = bus.term;
      if (bus.term_valid && r) got++;
      cyc++;
      step();
    end
    chk("done", bus.done, 1);
    chk("busy_in_done", bus.busy, 1);
    chk("count", got, exp_q.size());
    chk("ovf", bus.ovf, exp_ovf);
    if (rmode == 0) chk("latency", cyc, exp_q.size());
    step();
    chk("done_once", bus.done, 0);
    chk("busy_after", bus.busy, 0);
    chk("valid_after", bus.term_valid, 0);
    chk("ovf_sticky", bus.ovf, exp_ovf);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.n_terms = '0;
    bus.abort = 1'b0;
    bus.term_ready = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b1;
    step();
    run_seq(10, 0);
    run_seq(5, 1);
    run_seq(15, 0);
    run_seq(0, 0);
    run_seq(11, 0);
    run_seq(12, 2);
    repeat (6) run_seq(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    bus.abort = 1'b1;
    step();
    chk("abort_idle", bus.busy, 0);
    build_model(10);
    bus.term_ready = 1'b1;
    bus.start = 1'b1;
    bus.n_terms = C'(10);
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_wins", bus.term_valid, 1);
    step();
    bus.start = 1'b1;
    bus.n_terms = C'(2);
    step();
    bus.start = 1'b0;
    step();
    chk("ignored_start_idx", bus.term_idx, 3);
    chk("ignored_start_term", bus.term, exp_q[3]);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_valid", bus.term_valid, 0);
    chk("abort_busy", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", bus.done, 0);
      step();
    end
    bus.start = 1'b1;
    bus.n_terms = C'(10);
    step();
    bus.start = 1'b0;
    repeat (6) step();
    chk("pre_reset_idx", bus.term_idx, 6);
    chk("pre_reset_term", bus.term, exp_q[6]);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_zero("mid_reset");
    run_seq(3, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
